// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, register-zero constant and ALU control
//                encodings for the 5-stage pipelined CPU.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;

    // $0 is hard-wired to zero, so a write to it never creates a dependency.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detection. Flags the case
//                where the instruction in EX is a load whose destination is
//                read by the instruction in ID, which forwarding cannot cover.
//  Revision    : 1.0  initial release
//
//  Ports
//    ex_valid      in   EX stage holds a real instruction
//    ex_mem_read   in   EX instruction is a load
//    ex_write_reg  in   EX destination register
//    id_valid      in   ID stage holds a real instruction
//    id_rs/id_rt   in   ID source register specifiers
//    id_uses_rt    in   ID instruction reads Rt as an operand
//    ex_flush      in   taken branch/jump resolved in EX
//    hazard        out  raw load-use dependency
//    stall         out  hazard not masked by a flush
//    pc_write      out  PC update enable
//    if_id_write   out  IF/ID register enable
// ============================================================================
module hazard_detect #(
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_flush,
    output logic                  hazard,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  if_id_write
);
    import cpu_pkg::*;

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    always_comb begin
        ex_is_load  = ex_valid & ex_mem_read
                    & (ex_write_reg != REG_ADDR_W'(REG_ZERO));
        rs_match    = (ex_write_reg == id_rs);
        // Immediate-form instructions carry a destination in Rt, not a source.
        rt_match    = id_uses_rt & (ex_write_reg == id_rt);
        hazard      = ex_is_load & id_valid & (rs_match | rt_match);
        // A flush squashes the dependent instruction, so holding it is pointless.
        stall       = hazard & ~ex_flush;
        pc_write    = ~stall;
        if_id_write = ~stall;
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_hazard_stage
//  Description : ID/EX pipeline register with load-use hazard handling.
//                Captures decoded ID operands/control each cycle, inserts a
//                bubble on flush or load-use stall, drives PC/IF-ID enables
//                and keeps a saturating count of stall cycles.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst             clock (rising) and async active-high reset
//    ID_*                 decoded instruction from the ID stage
//    EX_Flush             taken branch/jump in EX, squash ID instruction
//    ID_EX_*              registered copies presented to EX
//    PC_Write, IF_ID_Write  front-end enables (low during a stall)
//    Stall                load-use stall this cycle
//    Stall_Count          saturating stall-cycle counter
// ============================================================================
module id_ex_hazard_stage #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = cpu_pkg::ALUOP_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRt,
    input  logic [REG_ADDR_W-1:0] ID_WriteReg,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  ID_MemWrite,
    input  logic                  ID_MemtoReg,
    input  logic                  ID_ALUSrc,
    input  logic                  ID_Branch,
    input  logic [ALUOP_W-1:0]    ID_ALUOp,
    input  logic [DATA_WIDTH-1:0] ID_Data1,
    input  logic [DATA_WIDTH-1:0] ID_Data2,
    input  logic [DATA_WIDTH-1:0] ID_Imm,
    input  logic [DATA_WIDTH-1:0] ID_PC4,
    input  logic                  EX_Flush,
    output logic                  ID_EX_Valid,
    output logic [REG_ADDR_W-1:0] ID_EX_Rs,
    output logic [REG_ADDR_W-1:0] ID_EX_Rt,
    output logic [REG_ADDR_W-1:0] ID_EX_WriteReg,
    output logic                  ID_EX_RegWrite,
    output logic                  ID_EX_MemRead,
    output logic                  ID_EX_MemWrite,
    output logic                  ID_EX_MemtoReg,
    output logic                  ID_EX_ALUSrc,
    output logic                  ID_EX_Branch,
    output logic [ALUOP_W-1:0]    ID_EX_ALUOp,
    output logic [DATA_WIDTH-1:0] ID_EX_Data1,
    output logic [DATA_WIDTH-1:0] ID_EX_Data2,
    output logic [DATA_WIDTH-1:0] ID_EX_Imm,
    output logic [DATA_WIDTH-1:0] ID_EX_PC4,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  Stall,
    output logic [CNT_W-1:0]      Stall_Count
);

    logic                  valid_q,     valid_d;
    logic [REG_ADDR_W-1:0] rs_q,        rs_d;
    logic [REG_ADDR_W-1:0] rt_q,        rt_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  alu_src_q,   alu_src_d;
    logic                  branch_q,    branch_d;
    logic [ALUOP_W-1:0]    alu_op_q,    alu_op_d;
    logic [DATA_WIDTH-1:0] data1_q,     data1_d;
    logic [DATA_WIDTH-1:0] data2_q,     data2_d;
    logic [DATA_WIDTH-1:0] imm_q,       imm_d;
    logic [DATA_WIDTH-1:0] pc4_q,       pc4_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic stall;
    logic pc_write;
    logic if_id_write;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .ex_valid     (valid_q),
        .ex_mem_read  (mem_read_q),
        .ex_write_reg (write_reg_q),
        .id_valid     (ID_Valid),
        .id_rs        (ID_Rs),
        .id_rt        (ID_Rt),
        .id_uses_rt   (ID_UsesRt),
        .ex_flush     (EX_Flush),
        .hazard       (hazard),
        .stall        (stall),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write)
    );

    // Next-state: the default is a fully zeroed bubble, which covers both the
    // flush and the stall case; only an unobstructed cycle captures ID.
    always_comb begin
        valid_d      = 1'b0;
        rs_d         = '0;
        rt_d         = '0;
        write_reg_d  = '0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        branch_d     = 1'b0;
        alu_op_d     = '0;
        data1_d      = '0;
        data2_d      = '0;
        imm_d        = '0;
        pc4_d        = '0;

        if (!EX_Flush && !stall) begin
            valid_d      = ID_Valid;
            rs_d         = ID_Rs;
            rt_d         = ID_Rt;
            write_reg_d  = ID_WriteReg;
            // An empty IF/ID slot must not leak side effects into EX/MEM/WB.
            reg_write_d  = ID_Valid & ID_RegWrite;
            mem_read_d   = ID_Valid & ID_MemRead;
            mem_write_d  = ID_Valid & ID_MemWrite;
            mem_to_reg_d = ID_Valid & ID_MemtoReg;
            alu_src_d    = ID_Valid & ID_ALUSrc;
            branch_d     = ID_Valid & ID_Branch;
            alu_op_d     = ID_Valid ? ID_ALUOp : '0;
            data1_d      = ID_Data1;
            data2_d      = ID_Data2;
            imm_d        = ID_Imm;
            pc4_d        = ID_PC4;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            alu_op_q     <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            imm_q        <= '0;
            pc4_q        <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            alu_op_q     <= alu_op_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            imm_q        <= imm_d;
            pc4_q        <= pc4_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ID_EX_Valid    = valid_q;
    assign ID_EX_Rs       = rs_q;
    assign ID_EX_Rt       = rt_q;
    assign ID_EX_WriteReg = write_reg_q;
    assign ID_EX_RegWrite = reg_write_q;
    assign ID_EX_MemRead  = mem_read_q;
    assign ID_EX_MemWrite = mem_write_q;
    assign ID_EX_MemtoReg = mem_to_reg_q;
    assign ID_EX_ALUSrc   = alu_src_q;
    assign ID_EX_Branch   = branch_q;
    assign ID_EX_ALUOp    = alu_op_q;
    assign ID_EX_Data1    = data1_q;
    assign ID_EX_Data2    = data2_q;
    assign ID_EX_Imm      = imm_q;
    assign ID_EX_PC4      = pc4_q;
    assign PC_Write       = pc_write;
    assign IF_ID_Write    = if_id_write;
    assign Stall          = stall;
    assign Stall_Count    = stall_cnt_q;

    // The raw hazard is only consumed through stall; keep it visible for debug.
    logic unused_hazard;
    assign unused_hazard = hazard;

endmodule : id_ex_hazard_stage
`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_hazard_stage
//  Description : Self-checking bench for id_ex_hazard_stage (CNT_W = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_hazard_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OW  = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst;
    logic          ID_Valid, ID_UsesRt;
    logic [AW-1:0] ID_Rs, ID_Rt, ID_WriteReg;
    logic          ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch;
    logic [OW-1:0] ID_ALUOp;
    logic [DW-1:0] ID_Data1, ID_Data2, ID_Imm, ID_PC4;
    logic          EX_Flush;
    logic          ID_EX_Valid;
    logic [AW-1:0] ID_EX_Rs, ID_EX_Rt, ID_EX_WriteReg;
    logic          ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
    logic          ID_EX_ALUSrc, ID_EX_Branch;
    logic [OW-1:0] ID_EX_ALUOp;
    logic [DW-1:0] ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC4;
    logic          PC_Write, IF_ID_Write, Stall;
    logic [CW-1:0] Stall_Count;

    id_ex_hazard_stage #(
        .DATA_WIDTH (DW), .REG_ADDR_W (AW), .ALUOP_W (OW), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst (rst),
        .ID_Valid (ID_Valid), .ID_Rs (ID_Rs), .ID_Rt (ID_Rt), .ID_UsesRt (ID_UsesRt),
        .ID_WriteReg (ID_WriteReg), .ID_RegWrite (ID_RegWrite), .ID_MemRead (ID_MemRead),
        .ID_MemWrite (ID_MemWrite), .ID_MemtoReg (ID_MemtoReg), .ID_ALUSrc (ID_ALUSrc),
        .ID_Branch (ID_Branch), .ID_ALUOp (ID_ALUOp), .ID_Data1 (ID_Data1),
        .ID_Data2 (ID_Data2), .ID_Imm (ID_Imm), .ID_PC4 (ID_PC4), .EX_Flush (EX_Flush),
        .ID_EX_Valid (ID_EX_Valid), .ID_EX_Rs (ID_EX_Rs), .ID_EX_Rt (ID_EX_Rt),
        .ID_EX_WriteReg (ID_EX_WriteReg), .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_MemRead (ID_EX_MemRead), .ID_EX_MemWrite (ID_EX_MemWrite),
        .ID_EX_MemtoReg (ID_EX_MemtoReg), .ID_EX_ALUSrc (ID_EX_ALUSrc),
        .ID_EX_Branch (ID_EX_Branch), .ID_EX_ALUOp (ID_EX_ALUOp),
        .ID_EX_Data1 (ID_EX_Data1), .ID_EX_Data2 (ID_EX_Data2), .ID_EX_Imm (ID_EX_Imm),
        .ID_EX_PC4 (ID_EX_PC4), .PC_Write (PC_Write), .IF_ID_Write (IF_ID_Write),
        .Stall (Stall), .Stall_Count (Stall_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The EX-stage instruction is held as one record; each edge either takes
    // the ID instruction or becomes an empty slot.
    typedef struct {
        bit       valid;
        int       rs, rt, wr;
        bit       rw, mr, mw, m2r, asrc, br;
        int       aluop;
        bit [31:0] d1, d2, imm, pc4;
    } instr_t;

    instr_t ex_m;
    int     cnt_m;

    function automatic instr_t empty_slot();
        instr_t e;
        e = '{valid: 0, rs: 0, rt: 0, wr: 0, rw: 0, mr: 0, mw: 0, m2r: 0, asrc: 0,
              br: 0, aluop: 0, d1: 0, d2: 0, imm: 0, pc4: 0};
        return e;
    endfunction

    // Load in EX whose result the ID instruction needs right now.
    function automatic bit model_stall();
        bit needs;
        needs = (int'(ID_Rs) == ex_m.wr) || (ID_UsesRt && int'(ID_Rt) == ex_m.wr);
        return ex_m.valid && ex_m.mr && ex_m.wr != 0 && ID_Valid && needs && !EX_Flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_m  <= empty_slot();
            cnt_m <= 0;
        end else begin
            if (EX_Flush || model_stall()) begin
                ex_m <= empty_slot();
            end else begin
                ex_m <= '{valid: ID_Valid, rs: int'(ID_Rs), rt: int'(ID_Rt),
                          wr: int'(ID_WriteReg),
                          rw: ID_Valid & ID_RegWrite, mr: ID_Valid & ID_MemRead,
                          mw: ID_Valid & ID_MemWrite, m2r: ID_Valid & ID_MemtoReg,
                          asrc: ID_Valid & ID_ALUSrc, br: ID_Valid & ID_Branch,
                          aluop: ID_Valid ? int'(ID_ALUOp) : 0,
                          d1: ID_Data1, d2: ID_Data2, imm: ID_Imm, pc4: ID_PC4};
            end
            if (model_stall()) cnt_m <= (cnt_m < CMAX) ? cnt_m + 1 : CMAX;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("valid",    32'(ID_EX_Valid),    32'(ex_m.valid));
        chk("rs",       32'(ID_EX_Rs),       32'(ex_m.rs));
        chk("rt",       32'(ID_EX_Rt),       32'(ex_m.rt));
        chk("wr",       32'(ID_EX_WriteReg), 32'(ex_m.wr));
        chk("regwrite", 32'(ID_EX_RegWrite), 32'(ex_m.rw));
        chk("memread",  32'(ID_EX_MemRead),  32'(ex_m.mr));
        chk("memwrite", 32'(ID_EX_MemWrite), 32'(ex_m.mw));
        chk("memtoreg", 32'(ID_EX_MemtoReg), 32'(ex_m.m2r));
        chk("alusrc",   32'(ID_EX_ALUSrc),   32'(ex_m.asrc));
        chk("branch",   32'(ID_EX_Branch),   32'(ex_m.br));
        chk("aluop",    32'(ID_EX_ALUOp),    32'(ex_m.aluop));
        chk("data1",    ID_EX_Data1,         ex_m.d1);
        chk("data2",    ID_EX_Data2,         ex_m.d2);
        chk("imm",      ID_EX_Imm,           ex_m.imm);
        chk("pc4",      ID_EX_PC4,           ex_m.pc4);
        chk("stall",    32'(Stall),          32'(model_stall()));
        chk("pc_write", 32'(PC_Write),       32'(!model_stall()));
        chk("ifid_wr",  32'(IF_ID_Write),    32'(!model_stall()));
        chk("count",    32'(Stall_Count),    32'(cnt_m));
    end

    // ---------------- stimulus ----------------
    // Applies one ID instruction 2 time units after the falling edge and
    // returns 1 unit later, before the next rising edge.
    task automatic step(input bit v, input int rs, input int rt, input bit ursrt,
                        input int wr, input bit rw, input bit mr, input bit mw,
                        input bit fl);
        @(negedge clk);
        #2;
        ID_Valid    = v;
        ID_Rs       = AW'(rs);
        ID_Rt       = AW'(rt);
        ID_UsesRt   = ursrt;
        ID_WriteReg = AW'(wr);
        ID_RegWrite = rw;
        ID_MemRead  = mr;
        ID_MemWrite = mw;
        ID_MemtoReg = mr;
        ID_ALUSrc   = mr | mw;
        ID_Branch   = 1'b0;
        ID_ALUOp    = OW'($urandom_range(0, 10));
        ID_Data1    = $urandom;
        ID_Data2    = $urandom;
        ID_Imm      = $urandom;
        ID_PC4      = $urandom;
        EX_Flush    = fl;
        #1;
    endtask

    task automatic lw8();   step(1, 1, 8, 0, 8, 1, 1, 0, 0); endtask
    task automatic nop();   step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        rst = 1'b1;
        ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_WriteReg = 0;
        ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemtoReg = 0;
        ID_ALUSrc = 0; ID_Branch = 0; ID_ALUOp = 0; ID_Data1 = 0; ID_Data2 = 0;
        ID_Imm = 0; ID_PC4 = 0; EX_Flush = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("lit_reset_valid", 32'(ID_EX_Valid), 0);
        chk("lit_reset_pcw",   32'(PC_Write),    1);
        chk("lit_reset_cnt",   32'(Stall_Count), 0);
        #1 rst = 1'b0;

        // Load-use on Rs: lw $8 ; add $9,$8,$10
        lw8();
        chk("lit_lw_nostall", 32'(Stall), 0);
        step(1, 8, 10, 1, 9, 1, 0, 0, 0);
        chk("lit_rs_stall", 32'(Stall),       1);
        chk("lit_rs_pcw",   32'(PC_Write),    0);
        chk("lit_rs_ifid",  32'(IF_ID_Write), 0);
        step(1, 8, 10, 1, 9, 1, 0, 0, 0);
        chk("lit_bubble_rw",  32'(ID_EX_RegWrite), 0);
        chk("lit_bubble_v",   32'(ID_EX_Valid),    0);
        chk("lit_retry_stall",32'(Stall),          0);
        nop();
        chk("lit_add_rs",  32'(ID_EX_Rs),       8);
        chk("lit_add_wr",  32'(ID_EX_WriteReg), 9);
        chk("lit_cnt1",    32'(Stall_Count),    1);

        // Rt ignored when not an operand: addi $9,$3,5 (Rt field = 8)
        lw8();
        step(1, 3, 8, 0, 9, 1, 0, 0, 0);
        chk("lit_addi_nostall", 32'(Stall), 0);
        nop();
        chk("lit_addi_rs", 32'(ID_EX_Rs), 3);

        // sw $8,0($3): Rt is an operand
        lw8();
        step(1, 3, 8, 1, 0, 0, 0, 1, 0);
        chk("lit_sw_stall", 32'(Stall), 1);
        step(1, 3, 8, 1, 0, 0, 0, 1, 0);
        chk("lit_sw_retry", 32'(Stall), 0);
        nop();
        chk("lit_sw_mw",  32'(ID_EX_MemWrite), 1);
        chk("lit_cnt2",   32'(Stall_Count),    2);

        // Load to $0 never stalls
        step(1, 1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 9, 1, 0, 0, 0);
        chk("lit_zero_nostall", 32'(Stall), 0);
        nop();
        chk("lit_zero_pass", 32'(ID_EX_Valid), 1);

        // Flush beats stall
        lw8();
        step(1, 8, 10, 1, 9, 1, 0, 0, 1);
        chk("lit_flush_stall", 32'(Stall),    0);
        chk("lit_flush_pcw",   32'(PC_Write), 1);
        nop();
        chk("lit_flush_bubble", 32'(ID_EX_Valid), 0);
        chk("lit_flush_cnt",    32'(Stall_Count), 2);

        // Back-to-back loads: lw $8 ; lw $9,0($8) ; add uses $9
        lw8();
        step(1, 8, 9, 0, 9, 1, 1, 0, 0);
        chk("lit_b2b_stall1", 32'(Stall), 1);
        step(1, 8, 9, 0, 9, 1, 1, 0, 0);
        step(1, 9, 10, 1, 11, 1, 0, 0, 0);
        chk("lit_b2b_stall2", 32'(Stall), 1);
        step(1, 9, 10, 1, 11, 1, 0, 0, 0);
        nop();
        chk("lit_cnt4", 32'(Stall_Count), 4);

        // Saturation: 20 more stall cycles push the 4-bit counter to its ceiling
        for (int i = 0; i < 20; i++) begin
            lw8();
            step(1, 8, 10, 1, 9, 1, 0, 0, 0);
            step(1, 8, 10, 1, 9, 1, 0, 0, 0);
        end
        nop();
        chk("lit_sat", 32'(Stall_Count), 15);

        // Mid-cycle reset with a stall pending
        lw8();
        step(1, 8, 10, 1, 9, 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("lit_mrst_valid", 32'(ID_EX_Valid),    0);
        chk("lit_mrst_rw",    32'(ID_EX_RegWrite), 0);
        chk("lit_mrst_mr",    32'(ID_EX_MemRead),  0);
        chk("lit_mrst_pcw",   32'(PC_Write),       1);
        chk("lit_mrst_ifid",  32'(IF_ID_Write),    1);
        chk("lit_mrst_cnt",   32'(Stall_Count),    0);
        @(negedge clk);
        #2 rst = 1'b0;
        lw8();
        nop();
        chk("lit_post_rst_wr", 32'(ID_EX_WriteReg), 8);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule : tb_id_ex_hazard_stage
`default_nettype wire

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register combined with load-use hazard detection for the 5-stage pipelined CPU. It captures decoded ID-stage operands and control each cycle and presents them to EX. These registered outputs include the Rs/Rt fields consumed by the forwarding unit. It detects load-use hazards that forwarding cannot cover, stalls PC and IF/ID, injects a bubble, honours branch flush from EX, and counts stall cycles for performance monitoring.

Parameters:
DATA_WIDTH, 32, register-file datapath width
REG_ADDR_W, 5, register specifier width
ALUOP_W, 4, ALU control field width
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
ID_Valid  in  1  IF/ID holds a real instruction
ID_Rs  in  REG_ADDR_W  source register 1 specifier
ID_Rt  in  REG_ADDR_W  source register 2 specifier
ID_UsesRt  in  1  instruction reads Rt as an operand (R-type, store, beq/bne)
ID_WriteReg  in  REG_ADDR_W  destination register after RegDst mux
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch  in  1 each  decoded control
ID_ALUOp  in  ALUOP_W  ALU control
ID_Data1, ID_Data2, ID_Imm, ID_PC4  in  DATA_WIDTH each  operands, sign-extended immediate, PC+4
EX_Flush  in  1  branch or jump resolved taken in EX; squash the instruction in ID
ID_EX_* (Valid, Rs, Rt, WriteReg, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp, Data1, Data2, Imm, PC4)  out  matching widths  registered EX-stage copies
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
Stall  out  1  load-use stall this cycle
Stall_Count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst=1): all ID_EX_* outputs become 0, giving a bubble with WriteReg=0. Stall_Count clears to 0. Outputs are released on the first clk edge after deassertion.
- Hazard term (combinational), all conditions required:
  - ID_EX_Valid & ID_EX_MemRead & (ID_EX_WriteReg != 0)
  - ID_Valid
  - (ID_EX_WriteReg == ID_Rs) | (ID_UsesRt & ID_EX_WriteReg == ID_Rt)
- Stall = hazard & ~EX_Flush. PC_Write = IF_ID_Write = ~Stall.
- Register update at each rising clk edge, in priority order:
  1. EX_Flush=1: load a bubble. The wrong-path instruction is dropped and no stall is needed.
  2. Stall=1: load a bubble. IF/ID holds, so the same instruction re-evaluates next cycle, when the load is in MEM and the forwarding unit can cover it.
  3. Otherwise: capture all ID_* inputs. ID_EX_Valid = ID_Valid. If ID_Valid=0, control bits are forced to 0.
- Bubble definition: Valid, RegWrite, MemRead, MemWrite, Branch, WriteReg, Rs and Rt are all 0. Data fields are also zeroed for determinism.
- Latency: one cycle from ID inputs to ID_EX_* outputs. A load-use pair costs exactly one stall cycle.
- A second hazard cannot follow directly, because the bubble has MemRead=0. Back-to-back loads each stall independently.
- Register $0: a load targeting $0 never stalls.
- Stall_Count increments on each edge where Stall=1 and saturates at all-ones (no wrap). It is cleared only by rst.
- Mid-operation reset: asynchronous clear regardless of pending stall or flush. PC_Write and IF_ID_Write read 1 while in reset, because the bubble makes the hazard term 0.

Decomposition:
- Shared package (cpu_pkg): REG_ADDR_W, DATA_WIDTH, ALUOP_W, REG_ZERO constant, ALUOp encodings.
- Sub-module hazard_detect: purely combinational hazard/stall logic.
- The register bank stays in id_ex_hazard_stage.

Test Plan:
1. Reset: assert rst mid-cycle with ID_RegWrite=1 -> all ID_EX_* go 0 immediately; PC_Write=1; Stall_Count=0.
2. Load-use on Rs: lw $8 in EX, add $9,$8,$10 in ID -> Stall=1 and PC_Write=IF_ID_Write=0 for one cycle; next ID_EX_RegWrite=0 (bubble); following cycle ID_EX_Rs=8 with no stall; Stall_Count=1.
3. Rt gating:
   - lw $8 in EX, addi $9,$8? no: addi $9,$3,5 with ID_Rt=8 and ID_UsesRt=0 -> no stall.
   - Same case with sw $8 and ID_UsesRt=1 -> stall.
4. Load to $0: lw $0 followed by add using $0 -> Stall=0; instruction passes through.
5. Flush priority: load-use hazard present and EX_Flush=1 in the same cycle -> Stall=0, PC_Write=1, bubble loaded, Stall_Count unchanged.
6. Saturation: CNT_W=4, force 20 hazard cycles -> Stall_Count reaches 15 and holds.
